sram_1r1w_param: RTL and testbench
==================================

Name: sram_1r1w_param

Overview:
- Parametrised single-clock 1R1W SRAM model; next generation of the L1 cache data/tag array macros.
- Generalises width, depth and byte granularity; read latency is configurable with a valid strobe.
- Adds a deterministic same-address read/write collision policy and a post-reset zero-initialisation sweep.
- Used by the L1 caches and any other on-chip array; drop-in target for future OpenRAM-compiled macros.

Parameters:
- DATA_WIDTH, 128, word width in bits; must be a multiple of BYTE_WIDTH.
- ADDR_WIDTH, 8, address width; depth = 2**ADDR_WIDTH.
- BYTE_WIDTH, 8, write-mask granularity in bits; NUM_WMASKS = DATA_WIDTH/BYTE_WIDTH.
- RD_LATENCY, 1, cycles from read request to rvalid; legal values 1..3.
- BYPASS, 1, collision policy: 1 = write-first (forward new bytes), 0 = read-first (old data).

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- we  in  1  write request.
- waddr  in  ADDR_WIDTH  write address.
- wmask  in  NUM_WMASKS  byte enables; bit i covers wdata[i*BYTE_WIDTH +: BYTE_WIDTH].
- wdata  in  DATA_WIDTH  write data.
- perr_inj  in  1  invert stored parity of bytes written this cycle (test only).
- re  in  1  read request.
- raddr  in  ADDR_WIDTH  read address.
- rdata  out  DATA_WIDTH  read data.
- rvalid  out  1  rdata valid strobe, one cycle per accepted read.
- rd_perr  out  NUM_WMASKS  per-byte parity error, qualified by rvalid.
- busy  out  1  init sweep in progress; requests ignored.

Behaviour:
- Reset (async assert, sync-to-clk deassert handled upstream): busy=1, rvalid=0, rdata=0, rd_perr=0, read pipeline flushed, FSM -> INIT, sweep counter=0.
- FSM INIT: each cycle writes all-zero data (and correct parity) to mem[cnt]; cnt increments. On cnt == 2**ADDR_WIDTH-1, write it and go to READY next cycle. busy=1 in INIT, 0 in READY. INIT lasts exactly 2**ADDR_WIDTH cycles.
- In INIT, we/re are ignored: no memory update, no rvalid.
- READY write: on posedge with we=1, bytes whose wmask bit is 1 update; others unchanged. wmask=0 is a no-op.
- READY read: re=1 sampled at edge T -> rdata/rvalid/rd_perr presented after edge T+RD_LATENCY-1, i.e. visible in cycle T+RD_LATENCY; rvalid high for exactly that one cycle. Back-to-back reads give one result per cycle, in order.
- rdata holds its last value while rvalid=0; it never goes X after reset.
- Collision (we & re & waddr==raddr, same edge): BYPASS=1 -> returned word = wdata bytes where wmask=1, old bytes elsewhere. BYPASS=0 -> entire old word. A write at T never affects a read sampled before T.
- Reads of addresses not yet written after the sweep return 0.
- Reset mid-operation: in-flight reads are dropped (no rvalid); memory is re-zeroed by a new sweep.

Optional Feature:
- Macro SRAM_PARITY_EN.
- With it: each byte stores one even-parity bit (inverted when perr_inj=1 during the write). On read, rd_perr[i]=1 if byte i parity mismatches; bypassed bytes use freshly computed parity (perr_inj applied).
- Without it: no parity storage; rd_perr tied 0; perr_inj ignored.

Decomposition:
- Package sram_pkg: state enum {INIT, READY}; RD_LATENCY min/max constants; function nwmasks(data_w, byte_w); parity function for one byte.
- Sub-module sram_rd_pipe: RD_LATENCY-deep valid/data/perr shift register with async reset; instantiated once for the read return path.

Test Plan:
- Reset, hold rst_n high -> busy=1 for exactly 256 cycles, then 0; re asserted during INIT yields no rvalid; read addr 0x05 afterwards -> 0.
- Write addr 0x10 data 0x0F0E..0100, wmask=16'hFFFF; then write same addr with wmask=16'h0001 data byte0=0xAA; read -> byte0=0xAA, other bytes unchanged; rvalid exactly RD_LATENCY cycles after re.
- RD_LATENCY=3: reads to 0x01,0x02,0x03 on consecutive cycles -> three rvalid pulses in order with matching data, no gaps.
- Same-edge write/read addr 0x20, old=all 0x11, wdata all 0x22, wmask=16'h00FF: BYPASS=1 -> low 8 bytes 0x22, high 8 bytes 0x11; BYPASS=0 -> all 0x11.
- Assert rst_n=0 one cycle after a read request with RD_LATENCY=2 -> no rvalid, rdata=0, busy=1, and a new 256-cycle sweep.
- SRAM_PARITY_EN: write addr 0x30 wmask=16'h0004 with perr_inj=1 -> read gives rd_perr=16'h0004; rewrite without injection -> rd_perr=0.

Source files
------------

// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types, constants and helpers for the 1R1W SRAM model
package sram_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 3;

    // Widest byte the parity helper accepts; narrower bytes are zero-extended
    localparam int PAR_MAX_W = 64;

    function automatic int nwmasks(input int data_w, input int byte_w);
        return data_w / byte_w;
    endfunction

    // Even-parity bit for one byte: makes the total count of ones even
    function automatic logic even_par(input logic [PAR_MAX_W-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// rtl/sram_rd_pipe.sv - read return shift register; data/perr hold while no valid arrives
module sram_rd_pipe #(
    parameter int LATENCY    = 1,
    parameter int DATA_WIDTH = 128,
    parameter int PERR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [PERR_WIDTH-1:0] in_perr,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [PERR_WIDTH-1:0] out_perr
);

    logic [LATENCY-1:0]    vld_q;
    logic [DATA_WIDTH-1:0] dat_q [LATENCY];
    logic [PERR_WIDTH-1:0] per_q [LATENCY];

    // Valid shifts every cycle; a stage's payload only moves when a valid word enters it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dat_q[i] <= '0;
                per_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_valid;
            if (in_valid) begin
                dat_q[0] <= in_data;
                per_q[0] <= in_perr;
            end
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                    per_q[i] <= per_q[i-1];
                end
            end
        end
    end

    assign out_valid = vld_q[LATENCY-1];
    assign out_data  = dat_q[LATENCY-1];
    assign out_perr  = per_q[LATENCY-1];

endmodule

// File: rtl/sram_1r1w_param.sv
// rtl/sram_1r1w_param.sv - parametrised 1R1W SRAM with zero sweep, collision policy and optional byte parity (SRAM_PARITY_EN)
module sram_1r1w_param
    import sram_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 8,
    parameter int BYTE_WIDTH = 8,
    parameter int RD_LATENCY = 1,
    parameter int BYPASS     = 1,
    localparam int NUM_WMASKS = nwmasks(DATA_WIDTH, BYTE_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [NUM_WMASKS-1:0] wmask,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  perr_inj,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic [NUM_WMASKS-1:0] rd_perr,
    output logic                  busy
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam int LAT   = (RD_LATENCY < RD_LAT_MIN) ? RD_LAT_MIN :
                           (RD_LATENCY > RD_LAT_MAX) ? RD_LAT_MAX : RD_LATENCY;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  rd_fire;
    logic                  collide;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [NUM_WMASKS-1:0] rd_perr_word;

    // Sweep state and address counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: walk every address once, then serve requests
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy    = 1'b0;
        case (state_q)
            INIT: begin
                busy  = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d = READY;
                end
            end
            READY: begin
                busy = 1'b0;
            end
            default: begin
                state_d = INIT;
                busy    = 1'b1;
            end
        endcase
    end

    // Array update: zero fill during the sweep, masked byte writes afterwards
    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            mem[cnt_q] <= '0;
        end else if (we) begin
            for (int i = 0; i < NUM_WMASKS; i++) begin
                if (wmask[i]) begin
                    mem[waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    assign rd_fire = re && (state_q == READY);
    assign collide = (BYPASS != 0) && we && (waddr == raddr);

    // Read word: old contents, with freshly written bytes forwarded under write-first
    always_comb begin
        rd_word = mem[raddr];
        for (int i = 0; i < NUM_WMASKS; i++) begin
            if (collide && wmask[i]) begin
                rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

`ifdef SRAM_PARITY_EN
    logic [NUM_WMASKS-1:0] pmem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_old;

    // Parity array tracks the data array; an injected error flips the stored bit
    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            pmem[cnt_q] <= '0;
        end else if (we) begin
            for (int i = 0; i < NUM_WMASKS; i++) begin
                if (wmask[i]) begin
                    pmem[waddr][i] <= even_par(PAR_MAX_W'(wdata[i*BYTE_WIDTH +: BYTE_WIDTH])) ^ perr_inj;
                end
            end
        end
    end

    assign rd_old = mem[raddr];

    // Per-byte check; a forwarded byte mismatches exactly when injection is active
    always_comb begin
        rd_perr_word = '0;
        for (int i = 0; i < NUM_WMASKS; i++) begin
            if (collide && wmask[i]) begin
                rd_perr_word[i] = perr_inj;
            end else begin
                rd_perr_word[i] = even_par(PAR_MAX_W'(rd_old[i*BYTE_WIDTH +: BYTE_WIDTH])) ^ pmem[raddr][i];
            end
        end
    end
`else
    logic unused_perr_inj;
    assign unused_perr_inj = perr_inj;
    assign rd_perr_word    = '0;
`endif

    sram_rd_pipe #(
        .LATENCY    (LAT),
        .DATA_WIDTH (DATA_WIDTH),
        .PERR_WIDTH (NUM_WMASKS)
    ) u_rd_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (rd_fire),
        .in_data   (rd_word),
        .in_perr   (rd_perr_word),
        .out_valid (rvalid),
        .out_data  (rdata),
        .out_perr  (rd_perr)
    );

endmodule

// File: tb/tb_sram_1r1w_param.sv
// tb/tb_sram_1r1w_param.sv - randomized and directed bench for three SRAM configurations sharing one stimulus
module tb_sram_1r1w_param;

    localparam int DW = 128;
    localparam int AW = 8;
    localparam int NW = 16;

`ifdef SRAM_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          we, re, perr_inj;
    logic [AW-1:0] waddr, raddr;
    logic [NW-1:0] wmask;
    logic [DW-1:0] wdata;

    logic [2:0][DW-1:0] rdata_v;
    logic [2:0]         rvalid_v;
    logic [2:0][NW-1:0] rperr_v;
    logic [2:0]         busy_v;

    int lat_t [3] = '{1, 2, 3};
    int byp_t [3] = '{1, 0, 1};

    always #5 clk = ~clk;

    sram_1r1w_param #(.RD_LATENCY(1), .BYPASS(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wmask(wmask), .wdata(wdata),
        .perr_inj(perr_inj), .re(re), .raddr(raddr), .rdata(rdata_v[0]), .rvalid(rvalid_v[0]),
        .rd_perr(rperr_v[0]), .busy(busy_v[0]));

    sram_1r1w_param #(.RD_LATENCY(2), .BYPASS(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wmask(wmask), .wdata(wdata),
        .perr_inj(perr_inj), .re(re), .raddr(raddr), .rdata(rdata_v[1]), .rvalid(rvalid_v[1]),
        .rd_perr(rperr_v[1]), .busy(busy_v[1]));

    sram_1r1w_param #(.RD_LATENCY(3), .BYPASS(1)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wmask(wmask), .wdata(wdata),
        .perr_inj(perr_inj), .re(re), .raddr(raddr), .rdata(rdata_v[2]), .rvalid(rvalid_v[2]),
        .rd_perr(rperr_v[2]), .busy(busy_v[2]));

    // Reference model state
    logic [DW-1:0] mem_m [256];
    logic [NW-1:0] pe_m [256];
    int            init_left;
    int            ecount = 0;
    logic          iss_v   [8];
    logic [DW-1:0] iss_wf  [8];
    logic [DW-1:0] iss_rf  [8];
    logic [NW-1:0] iss_pwf [8];
    logic [NW-1:0] iss_prf [8];
    logic [DW-1:0] last_d  [3];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        init_left = 256;
        for (int a = 0; a < 256; a++) begin
            mem_m[a] = '0;
            pe_m[a]  = '0;
        end
        for (int s = 0; s < 8; s++) iss_v[s] = 1'b0;
        for (int d = 0; d < 3; d++) last_d[d] = '0;
    endtask

    // One clock edge of the specified behaviour
    task automatic model_edge();
        int            slot;
        logic [DW-1:0] old, merged;
        logic [NW-1:0] pm;
        slot = ecount % 8;
        if (!rst_n) begin
            init_left   = 256;
            iss_v[slot] = 1'b0;
        end else if (init_left > 0) begin
            init_left--;
            iss_v[slot] = 1'b0;
        end else begin
            old    = mem_m[raddr];
            merged = old;
            pm     = pe_m[raddr];
            for (int i = 0; i < NW; i++) begin
                if (we && waddr == raddr && wmask[i]) begin
                    merged[i*8 +: 8] = wdata[i*8 +: 8];
                    pm[i]            = perr_inj;
                end
            end
            iss_v[slot]   = re;
            iss_wf[slot]  = merged;
            iss_rf[slot]  = old;
            iss_pwf[slot] = pm;
            iss_prf[slot] = pe_m[raddr];
            if (we) begin
                for (int i = 0; i < NW; i++) begin
                    if (wmask[i]) begin
                        mem_m[waddr][i*8 +: 8] = wdata[i*8 +: 8];
                        pe_m[waddr][i]         = perr_inj;
                    end
                end
            end
        end
        ecount++;
    endtask

    task automatic check_all();
        int            e, idx;
        logic          v;
        logic [NW-1:0] pexp;
        e = ecount - 1;
        for (int d = 0; d < 3; d++) begin
            idx  = e - lat_t[d] + 1;
            v    = (idx >= 0) ? iss_v[idx % 8] : 1'b0;
            pexp = '0;
            if (v) begin
                last_d[d] = (byp_t[d] != 0) ? iss_wf[idx % 8] : iss_rf[idx % 8];
                if (PAR) pexp = (byp_t[d] != 0) ? iss_pwf[idx % 8] : iss_prf[idx % 8];
            end
            chk($sformatf("busy%0d", d), DW'(busy_v[d]), DW'(init_left > 0));
            chk($sformatf("rvalid%0d", d), DW'(rvalid_v[d]), DW'(v));
            chk($sformatf("rdata%0d", d), rdata_v[d], last_d[d]);
            if (v) chk($sformatf("rd_perr%0d", d), DW'(rperr_v[d]), DW'(pexp));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        we = 1'b0; re = 1'b0; perr_inj = 1'b0; wmask = '0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NW-1:0] m, input logic inj);
        we = 1'b1; waddr = a; wdata = d; wmask = m; perr_inj = inj;
        tick();
        idle();
    endtask

    task automatic rd(input logic [AW-1:0] a);
        re = 1'b1; raddr = a;
        tick();
        idle();
    endtask

    function automatic logic [DW-1:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Run the post-reset sweep with random requests that must be ignored
    task automatic sweep(input string tag);
        int n;
        n = 0;
        while (busy_v[0] && n < 400) begin
            we = 1'($urandom); re = 1'($urandom);
            waddr = AW'($urandom); raddr = AW'($urandom);
            wmask = NW'($urandom); wdata = rnd_word(); perr_inj = 1'($urandom);
            tick();
            n++;
        end
        idle();
        chk(tag, DW'(n), DW'(256));
    endtask

    logic [DW-1:0] seq, exp_w, exp_wf, exp_rf;

    initial begin
        idle();
        waddr = '0; raddr = '0; wdata = '0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) tick();

        @(negedge clk);
        rst_n = 1'b1;
        sweep("sweep_len");

        rd(8'h05);
        tick(); tick();
        chk("rd05_zero", rdata_v[2], '0);

        for (int i = 0; i < NW; i++) seq[i*8 +: 8] = 8'(i);
        wr(8'h10, seq, 16'hFFFF, 1'b0);
        wr(8'h10, {120'h0, 8'hAA}, 16'h0001, 1'b0);
        rd(8'h10);
        tick(); tick();
        exp_w = seq;
        exp_w[7:0] = 8'hAA;
        for (int d = 0; d < 3; d++) chk($sformatf("merge%0d", d), rdata_v[d], exp_w);

        for (int a = 1; a <= 3; a++) wr(AW'(a), rnd_word(), 16'hFFFF, 1'b0);
        for (int a = 1; a <= 3; a++) begin
            re = 1'b1; raddr = AW'(a);
            tick();
        end
        idle();
        repeat (3) tick();

        wr(8'h20, {16{8'h11}}, 16'hFFFF, 1'b0);
        we = 1'b1; waddr = 8'h20; wdata = {16{8'h22}}; wmask = 16'h00FF;
        re = 1'b1; raddr = 8'h20;
        tick();
        idle();
        tick(); tick();
        exp_wf = {{8{8'h11}}, {8{8'h22}}};
        exp_rf = {16{8'h11}};
        chk("coll_wf_a", rdata_v[0], exp_wf);
        chk("coll_rf_b", rdata_v[1], exp_rf);
        chk("coll_wf_c", rdata_v[2], exp_wf);

        wr(8'h30, rnd_word(), 16'h0004, 1'b1);
        rd(8'h30);
        chk("par_inj_v", DW'(rvalid_v[0]), DW'(1));
        chk("par_inj", DW'(rperr_v[0]), PAR ? DW'(16'h0004) : '0);
        wr(8'h30, rnd_word(), 16'h0004, 1'b0);
        rd(8'h30);
        chk("par_clr", DW'(rperr_v[0]), '0);
        repeat (3) tick();

        for (int c = 0; c < 400; c++) begin
            we = 1'($urandom); re = 1'($urandom);
            waddr = AW'($urandom_range(0, 15)); raddr = AW'($urandom_range(0, 15));
            wmask = NW'($urandom); wdata = rnd_word(); perr_inj = 1'($urandom_range(0, 3) == 0);
            tick();
        end
        idle();
        repeat (3) tick();

        rd(8'h10);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_rvalid_b", DW'(rvalid_v[1]), '0);
        chk("rst_rdata_b", rdata_v[1], '0);
        chk("rst_busy_b", DW'(busy_v[1]), DW'(1));
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
        sweep("resweep_len");
        rd(8'h10);
        tick(); tick();
        for (int d = 0; d < 3; d++) chk($sformatf("rezero%0d", d), rdata_v[d], '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
